// File: rtl/icache_pkg.sv
// Shared types and geometry helpers for the set-associative instruction cache.
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MEM_READ,
        CACHE_UPDATE
    } state_t;

    function automatic int offset_w(input int words_per_block);
        return $clog2(words_per_block);
    endfunction

    function automatic int index_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_w(input int mem_aw, input int sets);
        return mem_aw - $clog2(sets);
    endfunction

endpackage

// File: rtl/icache_way.sv
// One cache way: line storage, valid bits, tag compare and word select.
// Valid bits reset and flush; tag and data storage are never cleared.
module icache_way
    import icache_pkg::*;
#(
    parameter int WORD_W          = 32,
    parameter int WORDS_PER_BLOCK = 4,
    parameter int SETS            = 8,
    parameter int MEM_AW          = 6,
    localparam int OFFSET_W       = offset_w(WORDS_PER_BLOCK),
    localparam int INDEX_W        = index_w(SETS),
    localparam int TAG_W          = tag_w(MEM_AW, SETS),
    localparam int LINE_W         = WORD_W * WORDS_PER_BLOCK
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                flush_all,
    input  logic [INDEX_W-1:0]  lookup_index,
    input  logic [TAG_W-1:0]    lookup_tag,
    input  logic [OFFSET_W-1:0] lookup_offset,
    output logic                lookup_hit,
    output logic                lookup_valid,
    output logic [WORD_W-1:0]   lookup_word,
    input  logic                fill,
    input  logic [INDEX_W-1:0]  fill_index,
    input  logic [TAG_W-1:0]    fill_tag,
    input  logic [LINE_W-1:0]   fill_data
);

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [LINE_W-1:0] data;
    } line_t;

    logic [SETS-1:0] valid_q;
    line_t           lines_q [SETS];
    line_t           cur_line;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
        end else if (flush_all) begin
            valid_q <= '0;
        end else if (fill) begin
            valid_q[fill_index] <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (fill) begin
            lines_q[fill_index].tag  <= fill_tag;
            lines_q[fill_index].data <= fill_data;
        end
    end

    assign cur_line     = lines_q[lookup_index];
    assign lookup_valid = valid_q[lookup_index];
    assign lookup_hit   = lookup_valid && (cur_line.tag == lookup_tag);
    assign lookup_word  = cur_line.data[int'(lookup_offset) * WORD_W +: WORD_W];

endmodule

// File: rtl/icache_sa.sv
// Set-associative read-only instruction cache with LRU replacement and flush.
// Optional ICACHE_PERF_CNT_EN adds saturating hit/miss counters.
module icache_sa
    import icache_pkg::*;
#(
    parameter int PC_W            = 32,
    parameter int WORD_W          = 32,
    parameter int WORDS_PER_BLOCK = 4,
    parameter int SETS            = 8,
    parameter int WAYS            = 2,
    parameter int MEM_AW          = 6
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              read,
    input  logic [PC_W-1:0]                   pc,
    input  logic                              flush,
    output logic [WORD_W-1:0]                 instruction,
    output logic                              busywait,
    output logic                              imem_read,
    output logic [MEM_AW-1:0]                 imem_address,
    input  logic [WORD_W*WORDS_PER_BLOCK-1:0] imem_readdata,
    input  logic                              imem_busywait
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0]                       hit_count,
    output logic [31:0]                       miss_count
`endif
);

    localparam int OFFSET_W = offset_w(WORDS_PER_BLOCK);
    localparam int INDEX_W  = index_w(SETS);
    localparam int TAG_W    = tag_w(MEM_AW, SETS);
    localparam int ADDR_TOP = 2 + OFFSET_W + INDEX_W + TAG_W;

    state_t              state_q;
    logic [MEM_AW-1:0]   miss_addr_q;
    logic                victim_q;
    logic                victim_d;
    logic                flush_pending_q;
    logic                flush_eff;
    logic                flush_all;
    logic                fill;

    logic [OFFSET_W-1:0] offset;
    logic [INDEX_W-1:0]  index;
    logic [TAG_W-1:0]    tag;
    logic [INDEX_W-1:0]  miss_index;
    logic [TAG_W-1:0]    miss_tag;

    logic [WAYS-1:0]     way_hit;
    logic [WAYS-1:0]     way_valid;
    logic [WORD_W-1:0]   way_word [WAYS];
    logic                hit;

    assign offset = pc[2 +: OFFSET_W];
    assign index  = pc[2 + OFFSET_W +: INDEX_W];
    assign tag    = pc[2 + OFFSET_W + INDEX_W +: TAG_W];

    logic unused_pc_lo;
    assign unused_pc_lo = ^pc[1:0];

    generate
        if (PC_W > ADDR_TOP) begin : g_pc_hi
            logic unused_pc_hi;
            assign unused_pc_hi = ^pc[PC_W-1:ADDR_TOP];
        end
    endgenerate

    assign miss_index = miss_addr_q[INDEX_W-1:0];
    assign miss_tag   = miss_addr_q[MEM_AW-1:INDEX_W];

    // A pending flush is only honoured once the controller is back in IDLE.
    assign flush_eff = flush || flush_pending_q;
    assign flush_all = (state_q == IDLE) && flush_eff;
    assign fill      = (state_q == MEM_READ) && !imem_busywait;

    genvar w;
    generate
        for (w = 0; w < WAYS; w++) begin : g_way
            icache_way #(
                .WORD_W          (WORD_W),
                .WORDS_PER_BLOCK (WORDS_PER_BLOCK),
                .SETS            (SETS),
                .MEM_AW          (MEM_AW)
            ) u_way (
                .clock         (clock),
                .reset         (reset),
                .flush_all     (flush_all),
                .lookup_index  (index),
                .lookup_tag    (tag),
                .lookup_offset (offset),
                .lookup_hit    (way_hit[w]),
                .lookup_valid  (way_valid[w]),
                .lookup_word   (way_word[w]),
                .fill          (fill && (int'(victim_q) == w)),
                .fill_index    (miss_index),
                .fill_tag      (miss_tag),
                .fill_data     (imem_readdata)
            );
        end
    endgenerate

    assign hit = read && (|way_hit);

    always_comb begin
        instruction = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (read && way_hit[i]) begin
                instruction = instruction | way_word[i];
            end
        end
    end

    assign busywait = (state_q != IDLE) || (read && !hit) || flush || flush_pending_q;

    // LRU bit per set names the way to evict next.
    generate
        if (WAYS == 2) begin : g_lru
            logic [SETS-1:0] lru_q;

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    lru_q <= '0;
                end else if (flush_all) begin
                    lru_q <= '0;
                end else if ((state_q == IDLE) && hit) begin
                    lru_q[index] <= way_hit[0];
                end else if (fill) begin
                    lru_q[miss_index] <= ~victim_q;
                end
            end

            assign victim_d = !way_valid[0] ? 1'b0 :
                              !way_valid[1] ? 1'b1 : lru_q[index];
        end else begin : g_no_lru
            logic unused_valid;
            assign unused_valid = ^way_valid;
            assign victim_d     = 1'b0;
        end
    endgenerate

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            miss_addr_q     <= '0;
            victim_q        <= 1'b0;
            flush_pending_q <= 1'b0;
            imem_read       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (flush_eff) begin
                        flush_pending_q <= 1'b0;
                    end else if (read && !hit) begin
                        miss_addr_q <= {tag, index};
                        victim_q    <= victim_d;
                        imem_read   <= 1'b1;
                        state_q     <= MEM_READ;
                    end
                end
                MEM_READ: begin
                    if (flush) begin
                        flush_pending_q <= 1'b1;
                    end
                    if (!imem_busywait) begin
                        imem_read <= 1'b0;
                        state_q   <= CACHE_UPDATE;
                    end
                end
                CACHE_UPDATE: begin
                    if (flush) begin
                        flush_pending_q <= 1'b1;
                    end
                    state_q <= IDLE;
                end
                default: begin
                    imem_read <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign imem_address = miss_addr_q;

`ifdef ICACHE_PERF_CNT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state_q == IDLE) begin
            if (flush_eff) begin
                hit_count  <= '0;
                miss_count <= '0;
            end else if (read && !hit) begin
                if (miss_count != 32'hFFFF_FFFF) begin
                    miss_count <= miss_count + 32'd1;
                end
            end else if (hit) begin
                if (hit_count != 32'hFFFF_FFFF) begin
                    hit_count <= hit_count + 32'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_icache_sa.sv
// Directed self-checking bench for icache_sa (default geometry: 4 words, 8 sets, 2 ways).
`timescale 1ns/1ps
module tb_icache_sa;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         read = 1'b0;
    logic [31:0]  pc = '0;
    logic         flush = 1'b0;
    logic [31:0]  instruction;
    logic         busywait;
    logic         imem_read;
    logic [5:0]   imem_address;
    logic [127:0] imem_readdata = '0;
    logic         imem_busywait = 1'b0;
`ifdef ICACHE_PERF_CNT_EN
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;
`endif

    int total = 0;
    int bad   = 0;

    localparam logic [127:0] BLK0 = 128'h0000000D_0000000C_0000000B_0000000A;
    localparam logic [127:0] BLK1 = 128'h0000001D_0000001C_0000001B_0000001A;
    localparam logic [127:0] BLK2 = 128'h0000002D_0000002C_0000002B_0000002A;

    always #5 clock = ~clock;

    icache_sa dut (
        .clock         (clock),
        .reset         (reset),
        .read          (read),
        .pc            (pc),
        .flush         (flush),
        .instruction   (instruction),
        .busywait      (busywait),
        .imem_read     (imem_read),
        .imem_address  (imem_address),
        .imem_readdata (imem_readdata),
        .imem_busywait (imem_busywait)
`ifdef ICACHE_PERF_CNT_EN
        ,
        .hit_count     (hit_count),
        .miss_count    (miss_count)
`endif
    );

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    // Serve a refill already in MEM_READ: busy for n cycles, then complete and return to IDLE.
    task automatic finish_refill(input int n, input logic [127:0] blk);
        imem_readdata = blk;
        imem_busywait = 1'b1;
        repeat (n) tick();
        imem_busywait = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        total++; if (busywait !== 1'b0) begin bad++; $display("FAIL rst_busywait got=%b want=0", busywait); end
        total++; if (imem_read !== 1'b0) begin bad++; $display("FAIL rst_imem_read got=%b want=0", imem_read); end
        total++; if (imem_address !== 6'd0) begin bad++; $display("FAIL rst_imem_address got=%0d want=0", imem_address); end
        total++; if (instruction !== 32'd0) begin bad++; $display("FAIL rst_instruction got=%h want=0", instruction); end
        reset = 1'b0;
        tick();
        read = 1'b1; pc = 32'h000; #1;
        total++; if (busywait !== 1'b1) begin bad++; $display("FAIL rst_read_miss got=%b want=1", busywait); end
        total++; if (instruction !== 32'd0) begin bad++; $display("FAIL rst_miss_instr got=%h want=0", instruction); end
        read = 1'b0;
    endtask

    task automatic test_cold_miss();
        read = 1'b1; pc = 32'h000; imem_readdata = BLK0; imem_busywait = 1'b0;
        tick();
        total++; if (imem_read !== 1'b1) begin bad++; $display("FAIL cold_imem_read got=%b want=1", imem_read); end
        total++; if (imem_address !== 6'd0) begin bad++; $display("FAIL cold_address got=%0d want=0", imem_address); end
        imem_busywait = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (imem_read !== 1'b1 || busywait !== 1'b1) begin bad++; $display("FAIL cold_wait%0d imem_read=%b busywait=%b want 1 1", i, imem_read, busywait); end
        end
        imem_busywait = 1'b0;
        tick();
        total++; if (imem_read !== 1'b0 || busywait !== 1'b1) begin bad++; $display("FAIL cold_update imem_read=%b busywait=%b want 0 1", imem_read, busywait); end
        tick();
        total++; if (busywait !== 1'b0) begin bad++; $display("FAIL cold_done_busywait got=%b want=0", busywait); end
        total++; if (instruction !== 32'h0000000A) begin bad++; $display("FAIL cold_done_instr got=%h want=0000000a", instruction); end
        pc = 32'h00C; #1;
        total++; if (instruction !== 32'h0000000D || busywait !== 1'b0) begin bad++; $display("FAIL cold_hit_00c instr=%h busywait=%b want 0000000d 0", instruction, busywait); end
        tick();
        pc = 32'h004; #1;
        total++; if (instruction !== 32'h0000000B) begin bad++; $display("FAIL cold_hit_004 got=%h want=0000000b", instruction); end
        read = 1'b0;
    endtask

    task automatic test_lru();
        read = 1'b1; pc = 32'h080; #1;
        total++; if (busywait !== 1'b1) begin bad++; $display("FAIL lru_080_miss got=%b want=1", busywait); end
        tick();
        total++; if (imem_address !== 6'd8) begin bad++; $display("FAIL lru_080_address got=%0d want=8", imem_address); end
        finish_refill(1, BLK1);
        total++; if (instruction !== 32'h0000001A || busywait !== 1'b0) begin bad++; $display("FAIL lru_080_fill instr=%h busywait=%b want 0000001a 0", instruction, busywait); end
        pc = 32'h000; #1;
        total++; if (instruction !== 32'h0000000A) begin bad++; $display("FAIL lru_000_hit got=%h want=0000000a", instruction); end
        tick();
        pc = 32'h100; #1;
        total++; if (busywait !== 1'b1) begin bad++; $display("FAIL lru_100_miss got=%b want=1", busywait); end
        tick();
        total++; if (imem_address !== 6'd16) begin bad++; $display("FAIL lru_100_address got=%0d want=16", imem_address); end
        finish_refill(2, BLK2);
        total++; if (instruction !== 32'h0000002A) begin bad++; $display("FAIL lru_100_fill got=%h want=0000002a", instruction); end
        pc = 32'h000; #1;
        total++; if (instruction !== 32'h0000000A || busywait !== 1'b0) begin bad++; $display("FAIL lru_000_kept instr=%h busywait=%b want 0000000a 0", instruction, busywait); end
        pc = 32'h080; #1;
        total++; if (busywait !== 1'b1 || instruction !== 32'd0) begin bad++; $display("FAIL lru_080_evicted busywait=%b instr=%h want 1 0", busywait, instruction); end
        read = 1'b0;
    endtask

    task automatic test_flush_idle();
        read = 1'b1; pc = 32'h000; flush = 1'b1; #1;
        total++; if (busywait !== 1'b1) begin bad++; $display("FAIL flush_cycle_busywait got=%b want=1", busywait); end
        tick();
        flush = 1'b0; #1;
        total++; if (busywait !== 1'b1 || instruction !== 32'd0) begin bad++; $display("FAIL flush_000_miss busywait=%b instr=%h want 1 0", busywait, instruction); end
        pc = 32'h100; #1;
        total++; if (busywait !== 1'b1) begin bad++; $display("FAIL flush_100_miss got=%b want=1", busywait); end
        read = 1'b0;
    endtask

    task automatic test_addr_latch();
        read = 1'b1; pc = 32'h000;
        tick();
        total++; if (imem_read !== 1'b1 || imem_address !== 6'd0) begin bad++; $display("FAIL latch_start imem_read=%b address=%0d want 1 0", imem_read, imem_address); end
        pc = 32'h040; read = 1'b0;
        imem_readdata = BLK0; imem_busywait = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (imem_read !== 1'b1 || imem_address !== 6'd0) begin bad++; $display("FAIL latch_hold%0d imem_read=%b address=%0d want 1 0", i, imem_read, imem_address); end
        end
        imem_busywait = 1'b0;
        tick();
        total++; if (imem_read !== 1'b0 || imem_address !== 6'd0) begin bad++; $display("FAIL latch_done imem_read=%b address=%0d want 0 0", imem_read, imem_address); end
        tick();
        read = 1'b1; #1;
        total++; if (busywait !== 1'b1) begin bad++; $display("FAIL latch_040_miss got=%b want=1", busywait); end
        pc = 32'h000; #1;
        total++; if (instruction !== 32'h0000000A || busywait !== 1'b0) begin bad++; $display("FAIL latch_000_hit instr=%h busywait=%b want 0000000a 0", instruction, busywait); end
        read = 1'b0;
    endtask

    task automatic test_flush_mid();
        read = 1'b1; pc = 32'h080;
        tick();
        total++; if (imem_address !== 6'd8) begin bad++; $display("FAIL fmid_address got=%0d want=8", imem_address); end
        imem_busywait = 1'b1; imem_readdata = BLK1; flush = 1'b1;
        tick();
        flush = 1'b0;
        total++; if (imem_read !== 1'b1) begin bad++; $display("FAIL fmid_not_aborted got=%b want=1", imem_read); end
        imem_busywait = 1'b0;
        tick();
        tick();
        total++; if (busywait !== 1'b1) begin bad++; $display("FAIL fmid_pending_busywait got=%b want=1", busywait); end
        tick();
        total++; if (busywait !== 1'b1 || instruction !== 32'd0) begin bad++; $display("FAIL fmid_080_invalid busywait=%b instr=%h want 1 0", busywait, instruction); end
        pc = 32'h000; #1;
        total++; if (busywait !== 1'b1) begin bad++; $display("FAIL fmid_000_invalid got=%b want=1", busywait); end
        read = 1'b0;
    endtask

    task automatic test_reset_mid();
        read = 1'b1; pc = 32'h000;
        tick();
        finish_refill(2, BLK0);
        total++; if (instruction !== 32'h0000000A || busywait !== 1'b0) begin bad++; $display("FAIL rmid_fill instr=%h busywait=%b want 0000000a 0", instruction, busywait); end
        pc = 32'h080;
        tick();
        total++; if (imem_read !== 1'b1) begin bad++; $display("FAIL rmid_in_mem_read got=%b want=1", imem_read); end
        imem_busywait = 1'b1;
        #2 reset = 1'b1; #1;
        total++; if (imem_read !== 1'b0 || imem_address !== 6'd0) begin bad++; $display("FAIL rmid_async imem_read=%b address=%0d want 0 0", imem_read, imem_address); end
        total++; if (busywait !== 1'b1) begin bad++; $display("FAIL rmid_read_busywait got=%b want=1", busywait); end
        read = 1'b0; #1;
        total++; if (busywait !== 1'b0 || instruction !== 32'd0) begin bad++; $display("FAIL rmid_idle busywait=%b instr=%h want 0 0", busywait, instruction); end
        @(negedge clock);
        reset = 1'b0; imem_busywait = 1'b0;
        read = 1'b1; pc = 32'h000; #1;
        total++; if (busywait !== 1'b1) begin bad++; $display("FAIL rmid_000_miss got=%b want=1", busywait); end
        read = 1'b0;
    endtask

`ifdef ICACHE_PERF_CNT_EN
    task automatic test_perf();
        reset = 1'b1; #3 reset = 1'b0;
        @(negedge clock);
        total++; if (hit_count !== 32'd0 || miss_count !== 32'd0) begin bad++; $display("FAIL perf_reset hit=%0d miss=%0d want 0 0", hit_count, miss_count); end
        read = 1'b1; pc = 32'h000;
        tick();
        finish_refill(0, BLK0);
        total++; if (miss_count !== 32'd1 || hit_count !== 32'd0) begin bad++; $display("FAIL perf_after_miss hit=%0d miss=%0d want 0 1", hit_count, miss_count); end
        tick();
        tick();
        total++; if (hit_count !== 32'd2) begin bad++; $display("FAIL perf_hits got=%0d want=2", hit_count); end
        flush = 1'b1;
        tick();
        flush = 1'b0; read = 1'b0;
        total++; if (hit_count !== 32'd0 || miss_count !== 32'd0) begin bad++; $display("FAIL perf_flush hit=%0d miss=%0d want 0 0", hit_count, miss_count); end
    endtask
`endif

    initial begin
        test_reset();
        test_cold_miss();
        test_lru();
        test_flush_idle();
        test_addr_latch();
        test_flush_mid();
        test_reset_mid();
`ifdef ICACHE_PERF_CNT_EN
        test_perf();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
